// File: rtl/cache_pkg.sv
// Shared definitions for the n-way FIFO-replacement cache: FSM encodings,
// line geometry and byte lane helpers.
package cache_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'b0001,
      S_TAGCMP = 4'b0010,
      S_FILL   = 4'b0100,
      S_WBACK  = 4'b1000
   } state_t;

   localparam int OFFSET_W = 2;
   localparam int LINE_W   = 32;

   function automatic logic [7:0] line_byte(input logic [LINE_W-1:0] line,
                                            input logic [OFFSET_W-1:0] off);
      return line[{off, 3'b000} +: 8];
   endfunction

   function automatic logic [LINE_W-1:0] line_merge(input logic [LINE_W-1:0] line,
                                                    input logic [OFFSET_W-1:0] off,
                                                    input logic [7:0] b);
      logic [LINE_W-1:0] r;
      r = line;
      r[{off, 3'b000} +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/nway_fifo_cache_if.sv
// CPU-side and memory-side buses of the cache; the cache is the slave,
// the CPU/memory environment is the master.
interface nway_fifo_cache_if #(
   parameter int ADDR_W = 16
);
   logic              req;
   logic              rw;
   logic [ADDR_W-1:0] memaddr;
   logic [7:0]        datafcpu;
   logic [7:0]        datatcpu;
   logic              rdy;
   logic              reqm;
   logic              rwm;
   logic [ADDR_W-1:0] rmemaddr;
   logic [31:0]       datatmem;
   logic [31:0]       datafmem;
   logic              rdym;

   modport slave (
      input  req, rw, memaddr, datafcpu, datafmem, rdym,
      output datatcpu, rdy, reqm, rwm, rmemaddr, datatmem
   );

   modport master (
      output req, rw, memaddr, datafcpu, datafmem, rdym,
      input  datatcpu, rdy, reqm, rwm, rmemaddr, datatmem
   );
endinterface

// File: rtl/cache_way.sv
// One cache way: tag/data RAM with registered write-first read, per-set
// valid/dirty flops and the hit compare against the addressed tag.
module cache_way
   import cache_pkg::*;
#(
   parameter int SET_BITS = 7,
   parameter int TAG_W    = 7
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SET_BITS-1:0] index,
   input  logic [TAG_W-1:0]    tag_in,
   input  logic                we,
   input  logic                fill,
   input  logic [LINE_W-1:0]   wr_line,
   output logic                hit,
   output logic                valid,
   output logic                dirty,
   output logic [TAG_W-1:0]    rd_tag,
   output logic [LINE_W-1:0]   rd_line
);
   localparam int SETS = 1 << SET_BITS;

   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [LINE_W-1:0] line_mem [SETS];
   logic [SETS-1:0]   valid_q, valid_d, dirty_q, dirty_d;
   logic [TAG_W-1:0]  rd_tag_q;
   logic [LINE_W-1:0] rd_line_q;

   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (we) begin
         if (fill) begin
            valid_d[index] = 1'b1;
            dirty_d[index] = 1'b0;
         end else begin
            dirty_d[index] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Read and write share the index, so forwarding the write makes the
   // following TAGCMP see a freshly filled or modified line.
   always_ff @(posedge clk) begin
      if (we) begin
         line_mem[index] <= wr_line;
         if (fill) tag_mem[index] <= tag_in;
      end
      rd_line_q <= we ? wr_line : line_mem[index];
      rd_tag_q  <= (we && fill) ? tag_in : tag_mem[index];
   end

   assign valid   = valid_q[index];
   assign dirty   = dirty_q[index];
   assign rd_tag  = rd_tag_q;
   assign rd_line = rd_line_q;
   assign hit     = valid_q[index] && (rd_tag_q == tag_in);

endmodule

// File: rtl/nway_fifo_cache.sv
// Set-associative write-back byte cache with per-set FIFO replacement,
// 4-byte lines and a single outstanding CPU transaction.
module nway_fifo_cache
   import cache_pkg::*;
#(
   parameter int  WAYS     = 2,
   parameter int  SET_BITS = 7,
   parameter int  ADDR_W   = 16,
   localparam int VW       = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   nway_fifo_cache_if.slave bus,
   output logic [3:0]       state,
   output logic [VW-1:0]    victim
);
   localparam int TAG_W = ADDR_W - SET_BITS - OFFSET_W;
   localparam int SETS  = 1 << SET_BITS;

   logic [OFFSET_W-1:0] offset;
   logic [SET_BITS-1:0] index;
   logic [TAG_W-1:0]    tag;
   logic [ADDR_W-1:0]   line_addr;

   assign offset    = bus.memaddr[OFFSET_W-1:0];
   assign index     = bus.memaddr[OFFSET_W +: SET_BITS];
   assign tag       = bus.memaddr[ADDR_W-1 -: TAG_W];
   assign line_addr = {bus.memaddr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

   logic [WAYS-1:0]   hit, valid, dirty, way_we;
   logic              way_fill;
   logic [LINE_W-1:0] wr_line, hit_line;
   logic [TAG_W-1:0]  way_tag  [WAYS];
   logic [LINE_W-1:0] way_line [WAYS];

   generate
      for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
         cache_way #(.SET_BITS(SET_BITS), .TAG_W(TAG_W)) u_way (
            .clk     (clk),
            .rst_n   (rst_n),
            .index   (index),
            .tag_in  (tag),
            .we      (way_we[gi]),
            .fill    (way_fill),
            .wr_line (wr_line),
            .hit     (hit[gi]),
            .valid   (valid[gi]),
            .dirty   (dirty[gi]),
            .rd_tag  (way_tag[gi]),
            .rd_line (way_line[gi])
         );
      end
   endgenerate

   state_t            state_q, state_d;
   logic              rdy_q, rdy_d, reqm_q, reqm_d, rwm_q, rwm_d;
   logic              from_ptr_q, from_ptr_d, pick_from_ptr, ptr_we;
   logic [7:0]        datatcpu_q, datatcpu_d;
   logic [ADDR_W-1:0] rmemaddr_q, rmemaddr_d;
   logic [LINE_W-1:0] datatmem_q, datatmem_d;
   logic [VW-1:0]     vsel_q, vsel_d, pick, ptr_d;
   logic [VW-1:0]     ptr_q [SETS];

   // Lowest invalid way wins; the FIFO pointer only matters for full sets.
   always_comb begin
      pick          = ptr_q[index];
      pick_from_ptr = 1'b1;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            pick          = VW'(i);
            pick_from_ptr = 1'b0;
         end
      end
      hit_line = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (hit[i]) hit_line = way_line[i];
      end
   end

   assign ptr_d = (WAYS > 1) ? ptr_q[index] + VW'(1) : '0;

   always_comb begin
      state_d    = state_q;
      rdy_d      = 1'b0;
      reqm_d     = reqm_q;
      rwm_d      = rwm_q;
      rmemaddr_d = rmemaddr_q;
      datatmem_d = datatmem_q;
      datatcpu_d = datatcpu_q;
      vsel_d     = vsel_q;
      from_ptr_d = from_ptr_q;
      way_we     = '0;
      way_fill   = 1'b0;
      wr_line    = bus.datafmem;
      ptr_we     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req && !rdy_q) state_d = S_TAGCMP;
         end
         S_TAGCMP: begin
            if (|hit) begin
               rdy_d   = 1'b1;
               state_d = S_IDLE;
               if (bus.rw) begin
                  way_we  = hit;
                  wr_line = line_merge(hit_line, offset, bus.datafcpu);
               end else begin
                  datatcpu_d = line_byte(hit_line, offset);
               end
            end else begin
               vsel_d     = pick;
               from_ptr_d = pick_from_ptr;
               reqm_d     = 1'b1;
               if (valid[pick] && dirty[pick]) begin
                  state_d    = S_WBACK;
                  rwm_d      = 1'b1;
                  rmemaddr_d = {way_tag[pick], index, {OFFSET_W{1'b0}}};
                  datatmem_d = way_line[pick];
               end else begin
                  state_d    = S_FILL;
                  rwm_d      = 1'b0;
                  rmemaddr_d = line_addr;
               end
            end
         end
         S_WBACK: begin
            if (bus.rdym) begin
               state_d    = S_FILL;
               rwm_d      = 1'b0;
               rmemaddr_d = line_addr;
            end
         end
         S_FILL: begin
            if (bus.rdym) begin
               way_we[vsel_q] = 1'b1;
               way_fill       = 1'b1;
               reqm_d         = 1'b0;
               ptr_we         = from_ptr_q;
               state_d        = S_TAGCMP;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rdy_q      <= 1'b0;
         reqm_q     <= 1'b0;
         rwm_q      <= 1'b0;
         rmemaddr_q <= '0;
         datatmem_q <= '0;
         datatcpu_q <= '0;
         vsel_q     <= '0;
         from_ptr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rdy_q      <= rdy_d;
         reqm_q     <= reqm_d;
         rwm_q      <= rwm_d;
         rmemaddr_q <= rmemaddr_d;
         datatmem_q <= datatmem_d;
         datatcpu_q <= datatcpu_d;
         vsel_q     <= vsel_d;
         from_ptr_q <= from_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
      end else if (ptr_we) begin
         ptr_q[index] <= ptr_d;
      end
   end

   assign bus.rdy      = rdy_q;
   assign bus.datatcpu = datatcpu_q;
   assign bus.reqm     = reqm_q;
   assign bus.rwm      = rwm_q;
   assign bus.rmemaddr = rmemaddr_q;
   assign bus.datatmem = datatmem_q;
   assign state        = state_q;
   assign victim       = ptr_q[index];

endmodule

// File: tb/tb_nway_fifo_cache.sv
// Scoreboard bench: a 2-way and a 4-way cache share one memory model; CPU
// reads and memory requests are checked against hand-computed queues.
module tb_nway_fifo_cache;

   typedef struct packed {
      logic       w;
      logic [7:0] b;
   } cpu_exp_t;

   typedef struct packed {
      logic        w;
      logic [15:0] a;
      logic [31:0] d;
   } mem_exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mem_stall = 1'b0;
   int   checks = 0;
   int   errors = 0;

   cpu_exp_t    exp_cpu[$];
   mem_exp_t    exp_mem[$];
   logic [31:0] mem_store [logic [15:0]];

   logic        req_s  [2];
   logic        rw_s   [2];
   logic [15:0] addr_s [2];
   logic [7:0]  dcpu_s [2];
   logic [1:0]       rdy_v;
   logic [1:0]       reqm_v;
   logic [1:0][3:0]  state_v;
   logic [1:0][1:0]  victim_v;

   always #5 clk = ~clk;

   // Untouched lines read back as {lo, hi, lo, hi} of their address.
   function automatic logic [31:0] mem_read(input logic [15:0] a);
      if (mem_store.exists(a)) return mem_store[a];
      if (a == 16'h1234) return 32'hAABBCCDD;
      return {a[7:0], a[15:8], a[7:0], a[15:8]};
   endfunction

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         localparam int W  = (gi == 0) ? 2 : 4;
         localparam int VW = $clog2(W);
         nway_fifo_cache_if #(.ADDR_W(16)) bus ();
         logic [VW-1:0] victim;
         cpu_exp_t      ce;
         mem_exp_t      me;
         int            cnt = 0;

         nway_fifo_cache #(.WAYS(W), .SET_BITS(7), .ADDR_W(16)) dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .bus    (bus),
            .state  (state_v[gi]),
            .victim (victim)
         );

         assign bus.req      = req_s[gi];
         assign bus.rw       = rw_s[gi];
         assign bus.memaddr  = addr_s[gi];
         assign bus.datafcpu = dcpu_s[gi];
         assign rdy_v[gi]    = bus.rdy;
         assign reqm_v[gi]   = bus.reqm;
         assign victim_v[gi] = 2'(victim);

         // CPU-side monitor
         always @(negedge clk) begin
            if (rst_n && bus.rdy === 1'b1) begin
               checks++;
               if (bus.reqm !== 1'b0) begin
                  errors++;
                  $display("FAIL rdy_with_reqm: dut%0d reqm=%0b required 0", gi, bus.reqm);
               end
               if (exp_cpu.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL cpu_unexpected: dut%0d rdy with data 0x%02h, none required", gi, bus.datatcpu);
               end else begin
                  ce = exp_cpu.pop_front();
                  $display("cpu  dut%0d %s addr=0x%04h data=0x%02h", gi, ce.w ? "WR" : "RD",
                           bus.memaddr, bus.datatcpu);
                  if (!ce.w) begin
                     checks++;
                     if (bus.datatcpu !== ce.b) begin
                        errors++;
                        $display("FAIL cpu_read: dut%0d addr=0x%04h got 0x%02h required 0x%02h",
                                 gi, bus.memaddr, bus.datatcpu, ce.b);
                     end
                  end
               end
            end
         end

         // Memory responder and monitor: acknowledges each request on its second cycle.
         always @(negedge clk) begin
            if (bus.rdym !== 1'b1 && bus.reqm === 1'b1 && !mem_stall) begin
               cnt++;
               bus.rdym = 1'b0;
               if (cnt >= 2) begin
                  cnt = 0;
                  checks++;
                  $display("mem  dut%0d %s addr=0x%04h wdata=0x%08h", gi, bus.rwm ? "WB" : "FILL",
                           bus.rmemaddr, bus.datatmem);
                  if (exp_mem.size() == 0) begin
                     errors++;
                     $display("FAIL mem_unexpected: dut%0d rwm=%0b addr=0x%04h, none required",
                              gi, bus.rwm, bus.rmemaddr);
                  end else begin
                     me = exp_mem.pop_front();
                     if (bus.rwm !== me.w || bus.rmemaddr !== me.a) begin
                        errors++;
                        $display("FAIL mem_req: dut%0d got rwm=%0b addr=0x%04h required rwm=%0b addr=0x%04h",
                                 gi, bus.rwm, bus.rmemaddr, me.w, me.a);
                     end
                     if (me.w) begin
                        checks++;
                        if (bus.datatmem !== me.d) begin
                           errors++;
                           $display("FAIL mem_wdata: dut%0d got 0x%08h required 0x%08h",
                                    gi, bus.datatmem, me.d);
                        end
                     end
                  end
                  if (bus.rwm) mem_store[bus.rmemaddr] = bus.datatmem;
                  else bus.datafmem = mem_read(bus.rmemaddr);
                  bus.rdym = 1'b1;
               end
            end else begin
               bus.rdym = 1'b0;
               cnt = 0;
            end
         end
      end
   endgenerate

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   task automatic exp_fill(input logic [15:0] a);
      exp_mem.push_back('{w: 1'b0, a: a, d: 32'h0});
   endtask

   task automatic exp_wb(input logic [15:0] a, input logic [31:0] d);
      exp_mem.push_back('{w: 1'b1, a: a, d: d});
   endtask

   // One CPU transaction; exp_lat != 0 also checks the req-to-rdy latency.
   task automatic cpu_op(input int k, input logic w, input logic [15:0] a,
                         input logic [7:0] d, input logic [7:0] exp_b, input int exp_lat);
      int n;
      exp_cpu.push_back('{w: w, b: exp_b});
      req_s[k]  = 1'b1;
      rw_s[k]   = w;
      addr_s[k] = a;
      dcpu_s[k] = d;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rdy_v[k] !== 1'b1 && n < 100);
      checks++;
      if (rdy_v[k] !== 1'b1) begin
         errors++;
         $display("FAIL cpu_timeout: dut%0d addr=0x%04h no rdy within %0d cycles", k, a, n);
      end else if (exp_lat != 0 && n != exp_lat) begin
         errors++;
         $display("FAIL cpu_latency: dut%0d addr=0x%04h got %0d cycles required %0d", k, a, n, exp_lat);
      end
      req_s[k] = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int n;
      for (int k = 0; k < 2; k++) begin
         req_s[k]  = 1'b0;
         rw_s[k]   = 1'b0;
         addr_s[k] = 16'h0;
         dcpu_s[k] = 8'h0;
      end
      repeat (3) @(negedge clk);
      check("reset_state",    32'(state_v[0]), 32'h1);
      check("reset_rdy",      32'(g_dut[0].bus.rdy), 32'h0);
      check("reset_reqm",     32'(g_dut[0].bus.reqm), 32'h0);
      check("reset_rwm",      32'(g_dut[0].bus.rwm), 32'h0);
      check("reset_datatcpu", 32'(g_dut[0].bus.datatcpu), 32'h0);
      check("reset_rmemaddr", 32'(g_dut[0].bus.rmemaddr), 32'h0);
      check("reset_datatmem", g_dut[0].bus.datatmem, 32'h0);
      check("reset_victim",   32'(victim_v[0]), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // cold read miss, then write/read hits on the same line
      exp_fill(16'h1234);
      cpu_op(0, 1'b0, 16'h1234, 8'h00, 8'hDD, 0);
      cpu_op(0, 1'b1, 16'h1235, 8'h55, 8'h00, 2);
      cpu_op(0, 1'b0, 16'h1235, 8'h00, 8'h55, 2);
      cpu_op(0, 1'b0, 16'h1236, 8'h00, 8'hBB, 2);

      // set 1: invalid ways fill first, then the pointer picks way 0
      exp_fill(16'h0004);
      cpu_op(0, 1'b0, 16'h0004, 8'h00, 8'h00, 0);
      exp_fill(16'h0204);
      cpu_op(0, 1'b0, 16'h0204, 8'h00, 8'h02, 0);
      check("victim_after_invalid_fills", 32'(victim_v[0]), 32'h0);
      exp_fill(16'h0404);
      cpu_op(0, 1'b0, 16'h0404, 8'h00, 8'h04, 0);
      check("victim_after_eviction", 32'(victim_v[0]), 32'h1);

      // dirty way 0 is written back before the new line is fetched
      do_reset();
      exp_fill(16'h0004);
      cpu_op(0, 1'b1, 16'h0005, 8'h99, 8'h00, 0);
      exp_fill(16'h0204);
      cpu_op(0, 1'b0, 16'h0204, 8'h00, 8'h02, 0);
      exp_wb(16'h0004, 32'h04009900);
      exp_fill(16'h0404);
      cpu_op(0, 1'b0, 16'h0404, 8'h00, 8'h04, 0);
      exp_fill(16'h0004);
      cpu_op(0, 1'b0, 16'h0005, 8'h00, 8'h99, 0);

      // reset while a fill is stalled abandons it and empties the cache
      mem_stall = 1'b1;
      req_s[0]  = 1'b1;
      rw_s[0]   = 1'b0;
      addr_s[0] = 16'h0804;
      n = 0;
      while (state_v[0] !== 4'b0100 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("stalled_fill_state", 32'(state_v[0]), 32'h4);
      repeat (3) @(negedge clk);
      rst_n    = 1'b0;
      req_s[0] = 1'b0;
      @(negedge clk);
      check("reset_mid_fill_state", 32'(state_v[0]), 32'h1);
      check("reset_mid_fill_reqm",  32'(reqm_v[0]), 32'h0);
      rst_n     = 1'b1;
      mem_stall = 1'b0;
      @(negedge clk);
      exp_fill(16'h0404);
      cpu_op(0, 1'b0, 16'h0404, 8'h00, 8'h04, 0);

      // 4-way instance: the fifth tag in one set evicts way 0
      mem_store.delete();
      for (int t = 0; t < 5; t++) begin
         exp_fill(16'h0004 + 16'(t * 16'h0200));
         cpu_op(1, 1'b0, 16'h0004 + 16'(t * 16'h0200), 8'h00, 8'(2 * t), 0);
         if (t == 3) check("w4_victim_full_set", 32'(victim_v[1]), 32'h0);
      end
      check("w4_victim_after_fifth", 32'(victim_v[1]), 32'h1);
      cpu_op(1, 1'b0, 16'h0204, 8'h00, 8'h02, 2);
      exp_fill(16'h0004);
      cpu_op(1, 1'b0, 16'h0004, 8'h00, 8'h00, 0);
      check("w4_victim_after_sixth", 32'(victim_v[1]), 32'h2);

      repeat (5) @(negedge clk);
      check("cpu_queue_drained", 32'(exp_cpu.size()), 32'h0);
      check("mem_queue_drained", 32'(exp_mem.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/nway_fifo_cache.md
NWAY_FIFO_CACHE -- requirements
Module: nway_fifo_cache

Interface
REQ-001 SHALL have parameter WAYS, default 2, number of ways per set (power of 2, 2..8).
REQ-002 SHALL have parameter SET_BITS, default 7, log2 of the set count.
REQ-003 SHALL have parameter ADDR_W, default 16, byte address width; offset is 2 bits (4-byte line), index is SET_BITS, tag is ADDR_W-SET_BITS-2.
REQ-004 SHALL have port clk  in  1  single clock, all logic on posedge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have CPU ports req in 1 (request, held until rdy), rw in 1 (1=write byte), memaddr in ADDR_W, datafcpu in 8, datatcpu out 8, rdy out 1 (one-cycle completion pulse).
REQ-007 SHALL have memory ports reqm out 1, rwm out 1 (1=write line), rmemaddr out ADDR_W (line-aligned), datatmem out 32, datafmem in 32, rdym in 1.
REQ-008 SHALL have debug ports state out 4 (one-hot FSM state) and victim out log2(WAYS) (FIFO pointer of the addressed set).

Function
REQ-009 SHALL implement FSM states IDLE=0001, TAGCMP=0010, WBACK=1000, FILL=0100.
REQ-010 IDLE: req=1 -> TAGCMP next cycle; otherwise stay; rdy=0.
REQ-011 TAGCMP hit (valid and tag match in any way): read returns addressed byte on datatcpu, write updates the byte and sets that way's dirty bit; rdy=1 for exactly the next cycle; -> IDLE.
REQ-012 Victim selection SHALL be the lowest-index invalid way if any; else the set's FIFO pointer.
REQ-013 TAGCMP miss with dirty valid victim: -> WBACK with reqm=1, rwm=1, rmemaddr={victim tag, index, 2'b00}, datatmem=victim line.
REQ-014 TAGCMP miss with clean or invalid victim: -> FILL with reqm=1, rwm=0, rmemaddr={memaddr[ADDR_W-1:2], 2'b00}.
REQ-015 WBACK: hold all memory outputs until rdym=1, then -> FILL with read request issued the same edge.
REQ-016 FILL: hold request until rdym=1; then write datafmem into victim, set valid, clear dirty, store tag, drop reqm, -> TAGCMP (which then hits).
REQ-017 FIFO pointer SHALL advance (mod WAYS) only on a fill whose victim came from the pointer; fills into invalid ways SHALL leave it unchanged.
REQ-018 Only one transaction in flight; req and memaddr are sampled continuously but SHALL be held stable by the CPU until rdy.
REQ-019 rdy SHALL never assert in the same cycle as reqm.
REQ-020 With WAYS=1 behaviour SHALL degrade to direct-mapped with pointer fixed at 0.

Reset
REQ-021 rst_n=0 at a clock edge SHALL force IDLE, rdy=0, reqm=0, rwm=0, datatcpu=0, rmemaddr=0, datatmem=0, and clear every valid bit, dirty bit and FIFO pointer.
REQ-022 Reset mid-WBACK or mid-FILL SHALL abandon the transfer (reqm=0 next cycle); data arrays need not be cleared.

Structure
REQ-023 SHALL place state encodings, offset width (2) and line width (32) in shared package cache_pkg.
REQ-024 SHALL use one sub-module cache_way (tag/valid/dirty/data storage and hit compare for one way), instantiated WAYS times by generate.

Verification
REQ-025 After reset, read 0x1234 -> FILL with rmemaddr=0x1234, memory returns 0xAABBCCDD, then rdy with datatcpu=0xDD (offset 0).
REQ-026 Write 0x55 to 0x1235 after REQ-025 -> rdy in 2 cycles from req, no reqm; read 0x1235 returns 0x55.
REQ-027 WAYS=2: fill 0x0004, 0x0204 (same set) -> ways 0,1, pointer stays 0; read 0x0404 -> evicts way 0, pointer becomes 1.
REQ-028 Dirty way 0 at set 1 (tag 0), miss to 0x0404 -> WBACK rmemaddr=0x0004 rwm=1 with written line, then FILL rmemaddr=0x0404.
REQ-029 rst_n=0 during FILL with rdym held 0 -> next cycle state=0001, reqm=0; subsequent read of prior address misses.
REQ-030 WAYS=4 parameter run: 5 distinct tags to one set -> fifth evicts way 0, victim output 1 afterwards.
